sdram_avalon_arbiter: RTL and testbench
=======================================

// Module: sdram_avalon_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single Avalon-MM slave port of sdram_controller_0 between NUM_M masters.
//  Masters are the Lua CPU fetch port, the Lua CPU data port and the HPS-to-FPGA bridge.
//  Sits in soc_system between the masters and the controller.
//  Supports pipelined reads: returned data is routed back to the master that issued the read, using a tag FIFO.
// PARAMETERS
//  NUM_M      3   number of masters (2..8); index 0 wins ties on the first arbitration after reset
//  ADDR_W     24  word address width (13 row + 2 bank + 9 col)
//  DATA_W     16  data width; byteenable width BE_W = DATA_W/8
//  MAX_PEND   8   outstanding read capacity (tag FIFO depth, power of 2)
// PORTS
//  clk              in   1             system clock
//  reset            in   1             synchronous, active-high
//  s_address        in   NUM_M*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
//  s_read           in   NUM_M         per-master read request
//  s_write          in   NUM_M         per-master write request
//  s_writedata      in   NUM_M*DATA_W  per-master write data
//  s_byteenable     in   NUM_M*BE_W    per-master byte enables
//  s_waitrequest    out  NUM_M         per-master stall
//  s_readdata       out  DATA_W        shared read data (qualify with s_readdatavalid)
//  s_readdatavalid  out  NUM_M         one-hot read-data valid
//  m_address        out  ADDR_W        to controller
//  m_read           out  1             to controller
//  m_write          out  1             to controller
//  m_writedata      out  DATA_W        to controller
//  m_byteenable     out  BE_W          to controller
//  m_waitrequest    in   1             from controller
//  m_readdata       in   DATA_W        from controller
//  m_readdatavalid  in   1             from controller
// BEHAVIOUR
//  Reset values
//   - m_read/m_write=0, s_readdatavalid=0, s_waitrequest=all 1.
//   - rr_ptr=0, lock=0, tag FIFO empty.
//  Eligibility
//   - Master i is eligible if (s_write[i]) or (s_read[i] and FIFO not full).
//   - A master holding both read and write is illegal; write wins.
//  Grant when lock=0
//   - Combinational, zero latency: first eligible index at or after rr_ptr, modulo NUM_M.
//  Grant when lock=1
//   - Grant is held on locked_id.
//  Mux
//   - The granted master's command is driven onto m_*.
//   - s_waitrequest[g] = m_waitrequest; all other s_waitrequest = 1.
//   - With no grant: m_read = m_write = 0.
//  Lock
//   - Set when a command is presented and m_waitrequest=1; cleared on acceptance.
//   - Keeps the Avalon command stable.
//   - Acceptance = (m_read|m_write) & !m_waitrequest.
//  Round-robin pointer
//   - On acceptance: rr_ptr <= g+1, wrapping NUM_M-1 -> 0.
//   - Otherwise unchanged.
//  Tag FIFO
//   - Push: on an accepted read, push g.
//   - Pop: on m_readdatavalid, pop the head id h.
//   - Routing: s_readdatavalid = 1<<h; s_readdata = m_readdata, registered 0 cycles.
//  FIFO boundaries
//   - Full = MAX_PEND entries. Reads are masked at full even if a pop occurs that cycle; writes are unaffected.
//   - Push and pop in the same cycle when not full: count is unchanged.
//   - Read-pointer and write-pointer wrap modulo MAX_PEND.
//   - m_readdatavalid while the FIFO is empty is a protocol error.
//     s_readdatavalid stays 0 and the sticky debug flag err_unexp is set.
//     err_unexp is cleared only by reset.
//  Reset mid-operation
//   - Lock, FIFO and rr_ptr are cleared next cycle; in-flight read data is dropped.
//   - The controller must be reset together with this block.
// TESTING
//  - Reset: hold reset 2 cycles -> m_read=m_write=0, s_waitrequest=3'b111, s_readdatavalid=0.
//  - Single master: s_read[1], addr 0x000123, m_waitrequest=0 -> m_address=0x000123 the same cycle.
//    Then m_readdatavalid with data 0xBEEF -> s_readdatavalid=3'b010, s_readdata=0xBEEF.
//  - Fairness: all 3 masters write continuously with m_waitrequest=0 -> grant order 0,1,2,0,1,2.
//  - Lock: master 2 writes 0x55AA, m_waitrequest=1 for 4 cycles while master 0 also requests.
//    m_* stays on master 2 for all 4 cycles; master 0 is granted the cycle after acceptance.
//  - FIFO full: 8 accepted reads with no readdatavalid -> 9th read stalls, and a write from another master still proceeds.
//    One readdatavalid -> the 9th read is accepted the next cycle.
//  - Out-of-order issue: reads from masters 2,0,1 -> three readdatavalid pulses route one-hot 100,001,010 in that order.

Source files
------------

// File: rtl/sdram_avalon_arbiter.sv
// Round-robin arbiter that shares one Avalon-MM SDRAM controller port between NUM_M masters.
// A tag FIFO remembers which master issued each read so pipelined read data goes back to it.
module sdram_avalon_arbiter #(
    parameter int NUM_M    = 3,
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_M*ADDR_W-1:0]       s_address,
    input  logic [NUM_M-1:0]              s_read,
    input  logic [NUM_M-1:0]              s_write,
    input  logic [NUM_M*DATA_W-1:0]       s_writedata,
    input  logic [NUM_M*(DATA_W/8)-1:0]   s_byteenable,
    output logic [NUM_M-1:0]              s_waitrequest,
    output logic [DATA_W-1:0]             s_readdata,
    output logic [NUM_M-1:0]              s_readdatavalid,
    output logic [ADDR_W-1:0]             m_address,
    output logic                          m_read,
    output logic                          m_write,
    output logic [DATA_W-1:0]             m_writedata,
    output logic [DATA_W/8-1:0]           m_byteenable,
    input  logic                          m_waitrequest,
    input  logic [DATA_W-1:0]             m_readdata,
    input  logic                          m_readdatavalid,
    output logic                          err_unexp
);

    localparam int BE_W  = DATA_W / 8;
    localparam int ID_W  = $clog2(NUM_M);
    localparam int PTR_W = $clog2(MAX_PEND);

    logic [ID_W-1:0]  rr_ptr;
    logic             lock;
    logic [ID_W-1:0]  locked_id;
    logic [ID_W-1:0]  tag_mem [MAX_PEND];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic             full;
    logic             empty;
    logic [NUM_M-1:0] eligible;
    logic [ID_W-1:0]  gnt;
    logic             gnt_valid;
    logic [ID_W-1:0]  first_any;
    logic [ID_W-1:0]  first_hi;
    logic             any_elig;
    logic             hi_elig;
    logic             cmd;
    logic             accept;
    logic             push;
    logic             pop;
    logic [ID_W-1:0]  head;

    assign full     = (count == (PTR_W+1)'(MAX_PEND));
    assign empty    = (count == '0);
    assign eligible = s_write | (s_read & {NUM_M{~full}});

    // Two scans: lowest eligible index at or above rr_ptr, else lowest eligible overall (wrap).
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        first_any = '0;
        first_hi  = '0;
        any_elig  = 1'b0;
        hi_elig   = 1'b0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any_elig  = 1'b1;
                first_any = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi_elig  = 1'b1;
                    first_hi = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        if (lock) begin
            gnt       = locked_id;
            gnt_valid = 1'b1;
        end else begin
            gnt       = hi_elig ? first_hi : first_any;
            gnt_valid = any_elig;
        end
    end

    always_comb begin
        m_address     = '0;
        m_writedata   = '0;
        m_byteenable  = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        s_waitrequest = '1;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_valid && gnt == ID_W'(i)) begin
                m_address        = s_address[i*ADDR_W +: ADDR_W];
                m_writedata      = s_writedata[i*DATA_W +: DATA_W];
                m_byteenable     = s_byteenable[i*BE_W +: BE_W];
                m_write          = s_write[i];
                m_read           = s_read[i] & ~s_write[i];
                s_waitrequest[i] = m_waitrequest;
            end
        end
    end

    assign cmd    = m_read | m_write;
    assign accept = cmd & ~m_waitrequest;
    assign push   = accept & m_read;
    assign pop    = m_readdatavalid & ~empty;
    assign head   = tag_mem[rd_ptr];

    always_comb begin
        s_readdatavalid = '0;
        for (int i = 0; i < NUM_M; i++) begin
            s_readdatavalid[i] = pop && (head == ID_W'(i));
        end
    end

    assign s_readdata = m_readdata;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            lock      <= 1'b0;
            locked_id <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            err_unexp <= 1'b0;
        end else begin
            lock <= cmd & m_waitrequest;
            if (cmd && m_waitrequest) locked_id <= gnt;
            if (accept) rr_ptr <= (gnt == ID_W'(NUM_M - 1)) ? '0 : gnt + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (m_readdatavalid && empty) err_unexp <= 1'b1;
        end
    end

    // NOTE: tag storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt;
    end

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Testbench for sdram_avalon_arbiter: directed vector table, then randomized traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_sdram_avalon_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] s_address;
    logic [2:0]  s_read;
    logic [2:0]  s_write;
    logic [47:0] s_writedata;
    logic [5:0]  s_byteenable;
    logic [2:0]  s_waitrequest;
    logic [15:0] s_readdata;
    logic [2:0]  s_readdatavalid;
    logic [23:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [15:0] m_writedata;
    logic [1:0]  m_byteenable;
    logic        m_waitrequest;
    logic [15:0] m_readdata;
    logic        m_readdatavalid;
    logic        err_unexp;

    sdram_avalon_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .m_byteenable   (m_byteenable),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .err_unexp      (err_unexp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [71:0] addr;
        logic        mwait;
        logic        mrdv;
        logic [15:0] mrdata;
        logic        e_rd;
        logic        e_wr;
        logic [23:0] e_addr;
        logic [15:0] e_wdata;
        logic [2:0]  e_wait;
        logic [2:0]  e_rdv;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic rst, input logic [2:0] rd, input logic [2:0] wr,
                           input logic [71:0] addr, input logic mwait, input logic mrdv,
                           input logic [15:0] mrdata, input logic e_rd, input logic e_wr,
                           input logic [23:0] e_addr, input logic [15:0] e_wdata,
                           input logic [2:0] e_wait, input logic [2:0] e_rdv, input logic e_err);
        vec_t v;
        v.rst = rst;     v.rd = rd;       v.wr = wr;       v.addr = addr;
        v.mwait = mwait; v.mrdv = mrdv;   v.mrdata = mrdata;
        v.e_rd = e_rd;   v.e_wr = e_wr;   v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_wait = e_wait; v.e_rdv = e_rdv; v.e_err = e_err;
        tbl.push_back(v);
    endtask

    logic [23:0] a_std [3] = '{24'h000100, 24'h000201, 24'h000302};
    logic [15:0] wd_std[3] = '{16'h1000, 16'h1001, 16'h55AA};

    // Reference model state: plain round-robin index, held master, queue of pending read owners.
    int  rr = 0;
    int  held = -1;
    int  mq[$];
    bit  merr = 1'b0;

    bit          crd[3];
    bit          cwr[3];
    logic [23:0] caddr[3];
    logic [15:0] cwd[3];
    logic [1:0]  cbe[3];

    initial begin
        logic [71:0] std_addr;
        logic [71:0] sgl_addr;
        std_addr = {a_std[2], a_std[1], a_std[0]};
        sgl_addr = {a_std[2], 24'h000123, a_std[0]};

        // reset
        add_vec(1, 0, 0, std_addr, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0);
        add_vec(1, 0, 0, std_addr, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0);
        // single master read, then its data
        add_vec(0, 3'b010, 0, sgl_addr, 0, 0, 0, 1, 0, 24'h000123, 0, 3'b101, 0, 0);
        add_vec(0, 0, 0, std_addr, 0, 1, 16'hBEEF, 0, 0, 0, 0, 3'b111, 3'b010, 0);
        // fairness: all write continuously
        add_vec(1, 0, 0, std_addr, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0);
        for (int k = 0; k < 6; k++)
            add_vec(0, 0, 3'b111, std_addr, 0, 0, 0, 0, 1, a_std[k%3], wd_std[k%3],
                    ~(3'b001 << (k%3)), 0, 0);
        // lock: master 2 stalled four cycles while master 0 also requests
        add_vec(0, 0, 3'b100, std_addr, 1, 0, 0, 0, 1, a_std[2], 16'h55AA, 3'b111, 0, 0);
        for (int k = 0; k < 3; k++)
            add_vec(0, 0, 3'b101, std_addr, 1, 0, 0, 0, 1, a_std[2], 16'h55AA, 3'b111, 0, 0);
        add_vec(0, 0, 3'b101, std_addr, 0, 0, 0, 0, 1, a_std[2], 16'h55AA, 3'b011, 0, 0);
        add_vec(0, 0, 3'b001, std_addr, 0, 0, 0, 0, 1, a_std[0], 16'h1000, 3'b110, 0, 0);
        // FIFO full
        add_vec(1, 0, 0, std_addr, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0);
        for (int k = 0; k < 8; k++)
            add_vec(0, 3'b001, 0, std_addr, 0, 0, 0, 1, 0, a_std[0], 0, 3'b110, 0, 0);
        add_vec(0, 3'b001, 3'b010, std_addr, 0, 0, 0, 0, 1, a_std[1], 16'h1001, 3'b101, 0, 0);
        add_vec(0, 3'b001, 0, std_addr, 0, 1, 16'h1234, 0, 0, 0, 0, 3'b111, 3'b001, 0);
        add_vec(0, 3'b001, 0, std_addr, 0, 0, 0, 1, 0, a_std[0], 0, 3'b110, 0, 0);
        // reads issued by 2,0,1 return in that order
        add_vec(1, 0, 0, std_addr, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0);
        add_vec(0, 3'b100, 0, std_addr, 0, 0, 0, 1, 0, a_std[2], 0, 3'b011, 0, 0);
        add_vec(0, 3'b001, 0, std_addr, 0, 0, 0, 1, 0, a_std[0], 0, 3'b110, 0, 0);
        add_vec(0, 3'b010, 0, std_addr, 0, 0, 0, 1, 0, a_std[1], 0, 3'b101, 0, 0);
        add_vec(0, 0, 0, std_addr, 0, 1, 16'hA002, 0, 0, 0, 0, 3'b111, 3'b100, 0);
        add_vec(0, 0, 0, std_addr, 0, 1, 16'hA000, 0, 0, 0, 0, 3'b111, 3'b001, 0);
        add_vec(0, 0, 0, std_addr, 0, 1, 16'hA001, 0, 0, 0, 0, 3'b111, 3'b010, 0);
        // unexpected read data sets the sticky flag until reset
        add_vec(0, 0, 0, std_addr, 0, 1, 16'hDEAD, 0, 0, 0, 0, 3'b111, 3'b000, 0);
        add_vec(0, 0, 0, std_addr, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1);
        add_vec(1, 0, 0, std_addr, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1);
        add_vec(0, 0, 0, std_addr, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0);

        s_writedata  = {wd_std[2], wd_std[1], wd_std[0]};
        s_byteenable = 6'h3F;

        foreach (tbl[n]) begin
            reset           = tbl[n].rst;
            s_read          = tbl[n].rd;
            s_write         = tbl[n].wr;
            s_address       = tbl[n].addr;
            m_waitrequest   = tbl[n].mwait;
            m_readdatavalid = tbl[n].mrdv;
            m_readdata      = tbl[n].mrdata;
            @(negedge clk);
            check($sformatf("row%0d_m_read", n), 64'(m_read), 64'(tbl[n].e_rd));
            check($sformatf("row%0d_m_write", n), 64'(m_write), 64'(tbl[n].e_wr));
            check($sformatf("row%0d_waitreq", n), 64'(s_waitrequest), 64'(tbl[n].e_wait));
            check($sformatf("row%0d_rdvalid", n), 64'(s_readdatavalid), 64'(tbl[n].e_rdv));
            check($sformatf("row%0d_err", n), 64'(err_unexp), 64'(tbl[n].e_err));
            if (tbl[n].e_rd || tbl[n].e_wr)
                check($sformatf("row%0d_m_address", n), 64'(m_address), 64'(tbl[n].e_addr));
            if (tbl[n].e_wr)
                check($sformatf("row%0d_m_writedata", n), 64'(m_writedata), 64'(tbl[n].e_wdata));
            if (tbl[n].e_rdv != 3'b000)
                check($sformatf("row%0d_readdata", n), 64'(s_readdata), 64'(tbl[n].mrdata));
            @(posedge clk);
            #1;
        end

        // Randomized traffic: masters hold each command until the model says it was accepted.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int  g;
            int  pop_pct;
            bit  full;
            bit  e_rd;
            bit  e_wr;
            bit  acc;
            logic [2:0] e_wait;
            logic [2:0] e_rdv;

            reset = (cyc == 0) || ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!crd[i] && !cwr[i] && $urandom_range(0, 2) == 0) begin
                    crd[i]   = $urandom_range(0, 1) == 1;
                    cwr[i]   = !crd[i] || ($urandom_range(0, 15) == 0);
                    caddr[i] = 24'($urandom);
                    cwd[i]   = 16'($urandom);
                    cbe[i]   = 2'($urandom);
                end
                s_read[i]                = crd[i];
                s_write[i]               = cwr[i];
                s_address[i*24 +: 24]    = caddr[i];
                s_writedata[i*16 +: 16]  = cwd[i];
                s_byteenable[i*2 +: 2]   = cbe[i];
            end
            pop_pct         = ((cyc / 400) % 2 == 0) ? 10 : 70;
            m_waitrequest   = $urandom_range(0, 3) == 0;
            m_readdatavalid = (mq.size() > 0) && ($urandom_range(0, 99) < pop_pct);
            m_readdata      = 16'($urandom);

            @(negedge clk);
            full = (mq.size() == 8);
            g = -1;
            if (held >= 0) g = held;
            else begin
                for (int k = 0; k < 3; k++) begin
                    int i;
                    i = (rr + k) % 3;
                    if (g < 0 && (cwr[i] || (crd[i] && !full))) g = i;
                end
            end
            e_rd   = (g >= 0) && crd[g] && !cwr[g];
            e_wr   = (g >= 0) && cwr[g];
            e_wait = 3'b111;
            if (g >= 0) e_wait[g] = m_waitrequest;
            e_rdv  = (m_readdatavalid && mq.size() > 0) ? 3'(1 << mq[0]) : 3'b000;

            check("rnd_m_read", 64'(m_read), 64'(e_rd));
            check("rnd_m_write", 64'(m_write), 64'(e_wr));
            check("rnd_waitreq", 64'(s_waitrequest), 64'(e_wait));
            check("rnd_rdvalid", 64'(s_readdatavalid), 64'(e_rdv));
            check("rnd_err", 64'(err_unexp), 64'(merr));
            if (e_rd || e_wr) check("rnd_m_address", 64'(m_address), 64'(caddr[g]));
            if (e_wr) begin
                check("rnd_m_writedata", 64'(m_writedata), 64'(cwd[g]));
                check("rnd_m_byteenable", 64'(m_byteenable), 64'(cbe[g]));
            end
            if (e_rdv != 3'b000) check("rnd_readdata", 64'(s_readdata), 64'(m_readdata));

            acc = (e_rd || e_wr) && !m_waitrequest;
            if (reset) begin
                rr = 0;
                held = -1;
                mq.delete();
                merr = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    crd[i] = 1'b0;
                    cwr[i] = 1'b0;
                end
            end else begin
                if (m_readdatavalid) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    else merr = 1'b1;
                end
                if (acc) begin
                    rr = (g + 1) % 3;
                    if (e_rd) mq.push_back(g);
                    held = -1;
                    crd[g] = 1'b0;
                    cwr[g] = 1'b0;
                end else if (e_rd || e_wr) begin
                    held = g;
                end else begin
                    held = -1;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
